// File: rtl/alu_seq.sv
// alu_seq
//   Handshaked, parametrised ALU. An operation is accepted on the input
//   valid/ready channel. The registered result and its N/Z/C/V flags are
//   offered on the output valid/ready channel until the consumer takes them.
//   Shifts move one bit per cycle through a working register. When the macro
//   ALU_BARREL_SHIFT_EN is defined, shifts are instead computed in the accept
//   cycle, and the SHIFT state and its counter are not built.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented
//   in_ready   block can accept an operation this cycle
//   a, b       operands (b is ignored by shifts)
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 ASR
//   shamt      shift amount, 0..WIDTH-1
//   out_valid  out/flags hold a result
//   out_ready  consumer takes the result this cycle
//   out        registered result
//   flags      registered {N, Z, C, V}
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;

    // Ready depends only on state, out_ready and reset: a held result can be
    // drained and replaced on the same edge.
    assign in_ready  = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_HOLD);

`ifdef ALU_BARREL_SHIFT_EN
    // The operand is padded by one bit so that the last bit shifted out lands
    // in the pad position: bit WIDTH for a left shift, bit 0 for a right shift.
    logic [WIDTH:0] sh_l;
    logic [WIDTH:0] sh_r;
    logic [WIDTH:0] sh_a;

    always_comb begin
        sh_l = {1'b0, a} << shamt;
        sh_r = {a, 1'b0} >> shamt;
        sh_a = $signed({a, 1'b0}) >>> shamt;
    end
`endif

    // Single-cycle result. Without the barrel shifter, this path only handles
    // shifts with shamt==0, which pass a through with C=0.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (op)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra bit of the difference is the unsigned borrow.
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];
                v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SHL: begin
                res_d = sh_l[WIDTH-1:0];
                c_d   = sh_l[WIDTH];
            end
            OP_SHR: begin
                res_d = sh_r[WIDTH:1];
                c_d   = sh_r[0];
            end
            OP_ASR: begin
                res_d = sh_a[WIDTH:1];
                c_d   = sh_a[0];
            end
`else
            OP_SHL, OP_SHR, OP_ASR: res_d = a;
`endif
            default: res_d = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [1:0]       sop;
    logic [WIDTH-1:0] step_res;
    logic             step_c;
    logic             is_iter;

    // Only a nonzero shift amount takes the multi-cycle path.
    assign is_iter = op[2] & (op[1:0] != 2'b00) & (shamt != '0);

    // One-bit step of the working register. sop holds the low op bits:
    // 01 SHL, 10 SHR, 11 ASR.
    always_comb begin
        step_res = work;
        step_c   = 1'b0;
        case (sop)
            2'b01: begin
                step_res = {work[WIDTH-2:0], 1'b0};
                step_c   = work[WIDTH-1];
            end
            2'b10: begin
                step_res = {1'b0, work[WIDTH-1:1]};
                step_c   = work[0];
            end
            default: begin
                step_res = {work[WIDTH-1], work[WIDTH-1:1]};
                step_c   = work[0];
            end
        endcase
    end
`endif

    // Control and result registers. An accept in HOLD drains the current
    // result and loads the next operation on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out   <= '0;
            flags <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            work  <= '0;
            cnt   <= '0;
            sop   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (is_iter) begin
                            work  <= a;
                            cnt   <= shamt;
                            sop   <= op[1:0];
                            state <= ST_SHIFT;
                        end else
`endif
                        begin
                            out   <= res_d;
                            flags <= {res_d[WIDTH-1], (res_d == '0), c_d, v_d};
                            state <= ST_HOLD;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    work <= step_res;
                    cnt  <= cnt - SHW'(1);
                    // The last step publishes its own result and carry.
                    if (cnt == SHW'(1)) begin
                        out   <= step_res;
                        flags <= {step_res[WIDTH-1], (step_res == '0), step_c, 1'b0};
                        state <= ST_HOLD;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit ALU. It computes a WIDTH-bit arithmetic, logic or shift result plus N/Z/C/V flags. Operands arrive on a valid/ready input channel, and the registered result and flags leave on a valid/ready output channel. Shifts run iteratively, one bit per cycle, unless the barrel-shifter option is compiled in. The block sits between the register file/operand bus and the writeback stage of the CPU datapath.

## Interface
- WIDTH, 8, datapath width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports (clock and reset first):
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored by shifts)
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 ASR
- shamt  input  SHW  shift amount, 0..WIDTH-1
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  registered result
- flags  output  4  registered {N, Z, C, V} (bit 3 = N … bit 0 = V)

## Operation
States:
- IDLE: empty.
- SHIFT: iterative shift in progress.
- HOLD: result held, out_valid=1.

Accept and hold:
- An operation is accepted on a rising clk edge when in_valid & in_ready.
- a, b, op and shamt are captured at accept and may change afterwards.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is forced 0 while rst_n is low.

Transitions:
- IDLE/HOLD, accept non-shift or shift with shamt==0 → result written to out/flags → HOLD.
- IDLE/HOLD, accept shift with shamt>0 → working reg = a, counter = shamt → SHIFT.
- SHIFT: each cycle, shift working reg by 1 and decrement counter. The cycle the counter reaches 0 writes out/flags → HOLD.
- HOLD, out_ready & !accept → IDLE.
- HOLD, out_ready & accept → new op proceeds per the rules above (drain and refill on the same edge).
- HOLD, !out_ready → out and flags stay frozen.

Arithmetic and flags:
- ADD: out = (a+b) mod 2^WIDTH; C = carry out; V = signed overflow.
- SUB: out = (a−b) mod 2^WIDTH; C = borrow (1 iff a < b unsigned); V = signed overflow.
- AND/OR/XOR: C = 0, V = 0.
- SHL/SHR: zero fill. ASR: sign fill. C = last bit shifted out (0 when shamt==0). V = 0.
- All ops: N = out[WIDTH-1]; Z = (out == 0).

Reset:
- rst_n low at an edge → state IDLE, out = 0, flags = 0, out_valid = 0.
- An in-flight shift or held result is discarded.

## Timing
- Latency is counted from the accept edge to the edge after which out_valid=1.
  - Non-shift, or shift with shamt==0: 1 cycle.
  - Iterative shift: shamt+1 cycles.
- Throughput: one op per cycle for 1-cycle ops when out_ready is held high.
- out_valid stays high until the out_ready handshake. out/flags do not change while out_valid & !out_ready.
- in_ready is combinational from state and out_ready only, with no path from in_valid.

## Configuration
- ALU_BARREL_SHIFT_EN defined:
  - Shifts are computed combinationally in the accept cycle, latency 1, same flag rules.
  - The SHIFT state and counter are not synthesised.
- ALU_BARREL_SHIFT_EN undefined: iterative shifter as described above.

## Test plan
(WIDTH=8)
- ADD a=0x7F b=0x01, out_ready=1 → one cycle later: out=0x80, flags N=1 Z=0 C=0 V=1, out_valid pulse of 1 cycle.
- SUB a=0x10 b=0x20 → out=0xF0, N=1 Z=0 C=1 V=0. Then SUB a=0x20 b=0x20 → out=0x00, Z=1 C=0.
- SHL a=0xA1 shamt=3 → out=0x08, C=1, N=0. out_valid after 4 cycles without the macro; after 1 cycle with ALU_BARREL_SHIFT_EN; in_ready=0 during SHIFT.
- ASR a=0x80 shamt=7 → out=0xFF, N=1 C=0. SHR a=0x80 shamt=0 → out=0x80, C=0, latency 1.
- Back-pressure:
  - XOR a=0xFF b=0xFF, out_ready=0 for 5 cycles → out=0x00, Z=1 stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (OR a=0x0F b=0xF0) → accepted the same edge; next cycle out=0xFF.
- Reset mid-shift: SHR a=0xF0 shamt=7, rst_n low on the 3rd SHIFT cycle → next edge out_valid=0, out=0x00, flags=0. With rst_n high, in_ready=1 and no stale result ever appears.
